// File: rtl/exec_issue_wb_pkg.sv
// rtl/exec_issue_wb_pkg.sv - shared ALU/format/condition codes, FSM states and widths for the execute stage
package exec_issue_wb_pkg;

  localparam int NREGS  = 16;
  localparam int XLEN   = 32;
  localparam int REG_AW = $clog2(NREGS);

  // ALU action codes understood by alu_total
  localparam logic [3:0] ALU_NOP = 4'h0;  // result = reg1 (load-immediate / move)
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_CND = 4'h6;  // result = CND_* code comparing reg0 with reg1

  // Operand formats; alu_total merges the low bytes into reg0
  localparam logic [1:0] FMT_1B = 2'd0;
  localparam logic [1:0] FMT_2B = 2'd1;
  localparam logic [1:0] FMT_4B = 2'd2;

  // Condition result codes produced by ALU_CND
  localparam logic [XLEN-1:0] CND_EQ   = 32'd1;
  localparam logic [XLEN-1:0] CND_MORE = 32'd2;
  localparam logic [XLEN-1:0] CND_LESS = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_issue_wb_if.sv
// rtl/exec_issue_wb_if.sv - issue, ALU, write-back and debug signals of the execute stage
interface exec_issue_wb_if;
  import exec_issue_wb_pkg::*;

  // issue handshake from the decoder
  logic              i_valid;
  logic              o_ready;
  logic [3:0]        i_action;
  logic [1:0]        i_fmt;
  logic [REG_AW-1:0] i_rd;
  logic [REG_AW-1:0] i_rs;
  logic              i_use_imm;
  logic [XLEN-1:0]   i_imm;
  // alu_total connection
  logic [XLEN-1:0]   o_alu_reg0;
  logic [XLEN-1:0]   o_alu_reg1;
  logic [3:0]        o_alu_action;
  logic [1:0]        o_alu_fmt;
  logic [XLEN-1:0]   i_alu_out;
  // write-back observation
  logic              o_wb_valid;
  logic [REG_AW-1:0] o_wb_rd;
  logic [XLEN-1:0]   o_wb_data;
  // debug register read
  logic [REG_AW-1:0] i_dbg_addr;
  logic [XLEN-1:0]   o_dbg_data;

  modport slave (
    input  i_valid, i_action, i_fmt, i_rd, i_rs, i_use_imm, i_imm, i_alu_out, i_dbg_addr,
    output o_ready, o_alu_reg0, o_alu_reg1, o_alu_action, o_alu_fmt,
           o_wb_valid, o_wb_rd, o_wb_data, o_dbg_data
  );

  modport master (
    output i_valid, i_action, i_fmt, i_rd, i_rs, i_use_imm, i_imm, i_alu_out, i_dbg_addr,
    input  o_ready, o_alu_reg0, o_alu_reg1, o_alu_action, o_alu_fmt,
           o_wb_valid, o_wb_rd, o_wb_data, o_dbg_data
  );

endinterface

// File: rtl/exec_issue_wb_regfile.sv
// rtl/exec_issue_wb_regfile.sv - regfile_16x32: 2 read + debug read, 1 write, async clear; ZERO_REG_EN pins R0 to 0
module regfile_16x32
  import exec_issue_wb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] rd0_addr_i,
  output logic [XLEN-1:0]   rd0_data_o,
  input  logic [REG_AW-1:0] rd1_addr_i,
  output logic [XLEN-1:0]   rd1_data_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [XLEN-1:0]   dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage: cleared on reset, one write per cycle (R0 writes dropped when hard-wired to zero)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
`ifdef ZERO_REG_EN
      if (wr_addr_i != '0) regs_q[wr_addr_i] <= wr_data_i;
`else
      regs_q[wr_addr_i] <= wr_data_i;
`endif
    end
  end

`ifdef ZERO_REG_EN
  assign rd0_data_o = (rd0_addr_i == '0) ? '0 : regs_q[rd0_addr_i];
  assign rd1_data_o = (rd1_addr_i == '0) ? '0 : regs_q[rd1_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
`else
  assign rd0_data_o = regs_q[rd0_addr_i];
  assign rd1_data_o = regs_q[rd1_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/exec_issue_wb.sv
// rtl/exec_issue_wb.sv - execute-stage sequencer around alu_total with write-back forwarding; option ZERO_REG_EN
module exec_issue_wb
  import exec_issue_wb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  exec_issue_wb_if.slave bus
);

  state_e state_q, state_d;

  logic              ready;
  logic              wb_valid;
  logic              accept;
  logic              fwd_en;

  logic [3:0]        action_q;
  logic [1:0]        fmt_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   op0_q;
  logic [XLEN-1:0]   op1_q;
  logic [XLEN-1:0]   res_q;

  logic [XLEN-1:0]   rf_rd0;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   op0_fwd;
  logic [XLEN-1:0]   op1_fwd;

  regfile_16x32 u_regfile (
    .clk_i      (i_clk),
    .rst_n_i    (i_rst_n),
    .rd0_addr_i (bus.i_rd),
    .rd0_data_o (rf_rd0),
    .rd1_addr_i (bus.i_rs),
    .rd1_data_o (rf_rd1),
    .dbg_addr_i (bus.i_dbg_addr),
    .dbg_data_o (bus.o_dbg_data),
    .we_i       (wb_valid),
    .wr_addr_i  (rd_q),
    .wr_data_i  (res_q)
  );

  // The result being written this cycle is not yet in the array, so bypass it.
  // A hard-wired R0 must keep reading 0 even while a discarded R0 write is in flight.
`ifdef ZERO_REG_EN
  assign fwd_en = (state_q == ST_WB) && (rd_q != '0);
`else
  assign fwd_en = (state_q == ST_WB);
`endif

  // Operand selection with write-back bypass
  always_comb begin
    op0_fwd = rf_rd0;
    op1_fwd = rf_rd1;
    if (fwd_en && (bus.i_rd == rd_q)) op0_fwd = res_q;
    if (fwd_en && (bus.i_rs == rd_q)) op1_fwd = res_q;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.i_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        ready    = 1'b1;
        wb_valid = 1'b1;
        state_d  = bus.i_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = bus.i_valid & ready;

  // Instruction latch on transfer and ALU result capture in the execute cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      action_q <= '0;
      fmt_q    <= '0;
      rd_q     <= '0;
      op0_q    <= '0;
      op1_q    <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        action_q <= bus.i_action;
        fmt_q    <= bus.i_fmt;
        rd_q     <= bus.i_rd;
        op0_q    <= op0_fwd;
        op1_q    <= bus.i_use_imm ? bus.i_imm : op1_fwd;
      end
      if (state_q == ST_EXEC) res_q <= bus.i_alu_out;
    end
  end

  // Ready is held low for the whole reset, even though the state already reads IDLE
  assign bus.o_ready      = ready & i_rst_n;
  assign bus.o_alu_reg0   = op0_q;
  assign bus.o_alu_reg1   = op1_q;
  assign bus.o_alu_action = action_q;
  assign bus.o_alu_fmt    = fmt_q;
  assign bus.o_wb_valid   = wb_valid;
  assign bus.o_wb_rd      = rd_q;
  assign bus.o_wb_data    = res_q;

endmodule

// File: tb/tb_exec_issue_wb.sv
// tb/tb_exec_issue_wb.sv - scoreboard bench for exec_issue_wb with a behavioural alu_total stand-in
module tb_exec_issue_wb;
  import exec_issue_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb_q[$];

  exec_issue_wb_if bus ();

  exec_issue_wb dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // behavioural alu_total: low bytes from the result, upper bytes kept from reg0
  function automatic logic [31:0] merge(input logic [1:0] fmt, input logic [31:0] base, input logic [31:0] r);
    case (fmt)
      FMT_1B:  return {base[31:8], r[7:0]};
      FMT_2B:  return {base[31:16], r[15:0]};
      default: return r;
    endcase
  endfunction

  logic [31:0] alu_y;
  always_comb begin
    alu_y = '0;
    case (bus.o_alu_action)
      ALU_NOP: alu_y = bus.o_alu_reg1;
      ALU_ADD: alu_y = merge(bus.o_alu_fmt, bus.o_alu_reg0, bus.o_alu_reg0 + bus.o_alu_reg1);
      ALU_SUB: alu_y = merge(bus.o_alu_fmt, bus.o_alu_reg0, bus.o_alu_reg0 - bus.o_alu_reg1);
      ALU_XOR: alu_y = merge(bus.o_alu_fmt, bus.o_alu_reg0, bus.o_alu_reg0 ^ bus.o_alu_reg1);
      ALU_CND: alu_y = (bus.o_alu_reg0 == bus.o_alu_reg1) ? CND_EQ :
                       (bus.o_alu_reg0 >  bus.o_alu_reg1) ? CND_MORE : CND_LESS;
      default: alu_y = '0;
    endcase
  end
  assign bus.i_alu_out = alu_y;

  // Called at a negedge: present one instruction, expect acceptance, return at the next negedge
  task automatic drive(input logic [3:0] act, input logic [1:0] fmt, input logic [3:0] rd,
                       input logic [3:0] rs, input logic use_imm, input logic [31:0] imm,
                       input logic [31:0] exp);
    wb_t e;
    bus.i_valid   = 1'b1;
    bus.i_action  = act;
    bus.i_fmt     = fmt;
    bus.i_rd      = rd;
    bus.i_rs      = rs;
    bus.i_use_imm = use_imm;
    bus.i_imm     = imm;
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready rd=%0d got %b want 1", rd, bus.o_ready);
    end
    e.rd   = rd;
    e.data = exp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid   = 1'b0;
    bus.i_action  = 4'($urandom);
    bus.i_rd      = 4'($urandom);
    bus.i_rs      = 4'($urandom);
    bus.i_imm     = $urandom;
  endtask

  // Called in the execute cycle: no write-back yet, then exactly one cycle later pop and compare
  task automatic wb_step(input string name);
    wb_t e;
    tests++;
    if (bus.o_wb_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s exec_cycle wb_valid=%b ready=%b want 0/0", name, bus.o_wb_valid, bus.o_ready);
    end
    @(negedge clk);
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (bus.o_wb_valid !== 1'b1 || bus.o_wb_rd !== e.rd || bus.o_wb_data !== e.data) begin
        fails++;
        $display("FAIL %s wb got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                 name, bus.o_wb_valid, bus.o_wb_rd, bus.o_wb_data, e.rd, e.data);
      end
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_action = '0; bus.i_fmt = '0; bus.i_rd = '0; bus.i_rs = '0;
    bus.i_use_imm = 1'b0; bus.i_imm = '0; bus.i_dbg_addr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.o_ready !== 1'b0 || bus.o_wb_valid !== 1'b0 || bus.o_alu_reg0 !== 32'h0 ||
        bus.o_alu_reg1 !== 32'h0 || bus.o_wb_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs ready=%b wb=%b reg0=%h reg1=%h wbd=%h want 0", bus.o_ready,
               bus.o_wb_valid, bus.o_alu_reg0, bus.o_alu_reg1, bus.o_wb_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready got %b want 1", bus.o_ready);
    end
    for (int a = 0; a < 16; a++) begin
      bus.i_dbg_addr = 4'(a);
      #1;
      tests++;
      if (bus.o_dbg_data !== 32'h0) begin
        fails++;
        $display("FAIL reset_reg R%0d got %h want 0", a, bus.o_dbg_data);
      end
    end
  endtask

  task automatic test_load_imm();
    drive(ALU_NOP, FMT_4B, 4'd3, 4'd0, 1'b1, 32'h12345678, 32'h12345678);
    tests++;
    if (bus.o_alu_reg1 !== 32'h12345678 || bus.o_alu_action !== ALU_NOP || bus.o_alu_fmt !== FMT_4B) begin
      fails++;
      $display("FAIL alu_ports reg1=%h act=%h fmt=%0d want 12345678/0/2",
               bus.o_alu_reg1, bus.o_alu_action, bus.o_alu_fmt);
    end
    wb_step("load_imm");
    @(negedge clk);
    bus.i_dbg_addr = 4'd3;
    #1;
    tests++;
    if (bus.o_dbg_data !== 32'h12345678) begin
      fails++;
      $display("FAIL load_imm_r3 got %h want 12345678", bus.o_dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    drive(ALU_NOP, FMT_4B, 4'd1, 4'd0, 1'b1, 32'd5, 32'd5);
    wb_step("b2b_load");
    drive(ALU_ADD, FMT_4B, 4'd1, 4'd0, 1'b1, 32'd7, 32'd12);
    tests++;
    if (bus.o_alu_reg0 !== 32'd5) begin
      fails++;
      $display("FAIL fwd_op0 got %h want 5", bus.o_alu_reg0);
    end
    wb_step("b2b_add");
    drive(ALU_ADD, FMT_4B, 4'd6, 4'd1, 1'b0, 32'hFFFF_FFFF, 32'd12);
    tests++;
    if (bus.o_alu_reg1 !== 32'd12) begin
      fails++;
      $display("FAIL fwd_op1 got %h want c", bus.o_alu_reg1);
    end
    wb_step("b2b_move");
    @(negedge clk);
    bus.i_dbg_addr = 4'd1;
    #1;
    tests++;
    if (bus.o_dbg_data !== 32'd12) begin
      fails++;
      $display("FAIL b2b_r1 got %h want c", bus.o_dbg_data);
    end
    bus.i_dbg_addr = 4'd6;
    #1;
    tests++;
    if (bus.o_dbg_data !== 32'd12) begin
      fails++;
      $display("FAIL b2b_r6 got %h want c", bus.o_dbg_data);
    end
  endtask

  task automatic test_fmt_merge();
    logic [1:0]  fmts [2] = '{FMT_1B, FMT_2B};
    logic [31:0] exps [2] = '{32'h0000_0000, 32'h0000_0100};
    for (int i = 0; i < 2; i++) begin
      drive(ALU_NOP, FMT_4B, 4'd2, 4'd0, 1'b1, 32'h0000_00FF, 32'h0000_00FF);
      wb_step("fmt_load");
      @(negedge clk);
      drive(ALU_ADD, fmts[i], 4'd2, 4'd0, 1'b1, 32'd1, exps[i]);
      wb_step("fmt_add");
      @(negedge clk);
    end
  endtask

  task automatic test_cnd();
    logic [31:0] imms [3] = '{32'd3, 32'd1, 32'd9};
    logic [31:0] exps [3] = '{CND_EQ, CND_MORE, CND_LESS};
    for (int i = 0; i < 3; i++) begin
      drive(ALU_NOP, FMT_4B, 4'd4, 4'd0, 1'b1, 32'd3, 32'd3);
      wb_step("cnd_load");
      drive(ALU_CND, FMT_4B, 4'd4, 4'd0, 1'b1, imms[i], exps[i]);
      wb_step("cnd");
      @(negedge clk);
      bus.i_dbg_addr = 4'd4;
      #1;
      tests++;
      if (bus.o_dbg_data !== exps[i]) begin
        fails++;
        $display("FAIL cnd_r4 imm=%0d got %h want %h", imms[i], bus.o_dbg_data, exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    drive(ALU_NOP, FMT_4B, 4'd7, 4'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wb_step("pre_reset");
    @(negedge clk);
    drive(ALU_NOP, FMT_4B, 4'd8, 4'd0, 1'b1, 32'h0000_0055, 32'h0000_0055);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    tests++;
    if (bus.o_wb_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset wb=%b ready=%b want 0/0", bus.o_wb_valid, bus.o_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (bus.o_wb_valid !== 1'b0) begin
        fails++;
        $display("FAIL dropped_wb cycle %0d got %b want 0", c, bus.o_wb_valid);
      end
    end
    for (int a = 7; a < 9; a++) begin
      bus.i_dbg_addr = 4'(a);
      #1;
      tests++;
      if (bus.o_dbg_data !== 32'h0) begin
        fails++;
        $display("FAIL mid_reset_reg R%0d got %h want 0", a, bus.o_dbg_data);
      end
    end
  endtask

  task automatic test_r0();
    logic [31:0] r0_exp;
`ifdef ZERO_REG_EN
    r0_exp = 32'h0;
`else
    r0_exp = 32'hAA;
`endif
    drive(ALU_NOP, FMT_4B, 4'd0, 4'd0, 1'b1, 32'hAA, 32'hAA);
    wb_step("r0_write");
    drive(ALU_ADD, FMT_4B, 4'd1, 4'd0, 1'b0, 32'h0, r0_exp);
    wb_step("r0_fwd");
    @(negedge clk);
    bus.i_dbg_addr = 4'd0;
    #1;
    tests++;
    if (bus.o_dbg_data !== r0_exp) begin
      fails++;
      $display("FAIL r0_read got %h want %h", bus.o_dbg_data, r0_exp);
    end
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_back_to_back();
    @(negedge clk);
    test_fmt_merge();
    test_cnd();
    test_reset_mid_exec();
    test_r0();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
